vdma_out_pacer: RTL and testbench

//  Parametrised successor to vdma_ctrl_v2. Sits between VDMA MM2S AXIS output and downstream video sink.

---
 rtl/vdma_pkg.sv | 18 +
 rtl/vdma_out_pacer_if.sv | 23 ++
 rtl/axis_sync_fifo.sv | 50 +++++
 rtl/vdma_out_pacer.sv | 252 +++++++++++++++++++++++++
 tb/tb_vdma_out_pacer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdma_pkg.sv
// vdma_out_pacer shared types: FSM state encoding and FIFO entry width.
// No ports; imported by the pacer top.
package vdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SOF  = 3'd1,
    ST_LINE      = 3'd2,
    ST_LINE_GAP  = 3'd3,
    ST_FRAME_GAP = 3'd4
  } state_t;

  // FIFO entry is {tuser, tlast, tdata}
  function automatic int fifo_width(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/vdma_out_pacer_if.sv
// AXI-Stream video beat bundle: tdata/tlast/tuser/tvalid/tready.
// master drives the beat, slave drives tready.
interface vdma_out_pacer_if #(
  parameter int TDATA_WIDTH = 64
);

  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic                   tuser;
  logic                   tvalid;
  logic                   tready;

  modport master (
    output tdata, tlast, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tlast, tuser, tvalid,
    output tready
  );

endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO; head word readable the cycle after its write.
// Ports: clk, rst_n, wr_en/wr_data/full, rd_en/rd_data/empty.
module axis_sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;
  localparam ptr_t PONE = ptr_t'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;

  // extra pointer bit separates full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + PONE;
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + PONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/vdma_out_pacer.sv
// Re-times VDMA MM2S beats into frames with counter tuser/tlast and gaps.
// Ports: clk/rst, enable/mode, geometry+gaps, s/m AXIS, frame_cnt, flags.
module vdma_out_pacer
  import vdma_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_aresetn,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] vdma_row,
  input  logic [CNT_WIDTH-1:0] vdma_column,
  input  logic [CNT_WIDTH-1:0] line_gap,
  input  logic [CNT_WIDTH-1:0] frame_gap,
  vdma_out_pacer_if.slave      s_axis_mm2s,
  vdma_out_pacer_if.master     m_axis_mm2s,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 underflow,
  output logic                 sync_err,
  output logic                 cfg_err
);

  localparam int FW = fifo_width(TDATA_WIDTH);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  state_t state, state_d;

  logic          rst_done;
  logic          in_rdy;
  logic          f_full;
  logic          f_empty;
  logic          rd_en;
  logic [FW-1:0] f_wr;
  logic [FW-1:0] f_rd;

  logic                   h_user;
  logic                   h_last;
  logic [TDATA_WIDTH-1:0] h_data;

  cnt_t row_q, col_q, lgap_q, fgap_q;
  logic paced_q;
  cnt_t beat_cnt, line_cnt, gap_cnt;

  logic                   m_valid;
  logic [TDATA_WIDTH-1:0] m_data;
  logic                   m_user;
  logic                   m_last;
  logic                   out_final;
  logic                   out_bad;

  logic load_ok;
  logic gen_user;
  logic gen_last;
  logic final_line;
  logic line_end;
  logic beat_bad;
  logic in_gap;
  cnt_t gap_lim;
  logic gap_done;
  logic emit;
  logic sof;
  logic drop_cfg;

  // tready stays low until the first edge out of reset
  assign in_rdy = rst_done & ~f_full;
  assign s_axis_mm2s.tready = in_rdy;

  assign f_wr = {s_axis_mm2s.tuser,
                 s_axis_mm2s.tlast,
                 s_axis_mm2s.tdata};

  axis_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (s_axis_aclk),
    .rst_n   (s_axis_aresetn),
    .wr_en   (s_axis_mm2s.tvalid & in_rdy),
    .wr_data (f_wr),
    .full    (f_full),
    .rd_en   (rd_en),
    .rd_data (f_rd),
    .empty   (f_empty)
  );

  assign h_user = f_rd[FW-1];
  assign h_last = f_rd[FW-2];
  assign h_data = f_rd[TDATA_WIDTH-1:0];

  assign m_axis_mm2s.tvalid = m_valid;
  assign m_axis_mm2s.tdata  = m_data;
  assign m_axis_mm2s.tuser  = m_user;
  assign m_axis_mm2s.tlast  = m_last;

  // output register free after this edge
  assign load_ok = ~m_valid | m_axis_mm2s.tready;

  assign gen_user   = (beat_cnt == '0) && (line_cnt == '0);
  assign gen_last   = (beat_cnt == row_q - ONE);
  assign final_line = (line_cnt == col_q - ONE);

  // pass-through ends lines on the source tlast
  assign line_end = paced_q ? gen_last : h_last;

  assign beat_bad = (h_user & ~gen_user) |
                    (h_last ^ gen_last);

  assign in_gap  = (state == ST_LINE_GAP) ||
                   (state == ST_FRAME_GAP);
  assign gap_lim = (state == ST_FRAME_GAP) ? fgap_q
                                           : lgap_q;
  // a zero gap still spends one cycle in the state
  assign gap_done = (gap_lim == '0) ||
                    (gap_cnt == gap_lim - ONE);

  always_comb begin
    state_d  = state;
    rd_en    = 1'b0;
    emit     = 1'b0;
    sof      = 1'b0;
    drop_cfg = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable)
          state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!f_empty) begin
          if (!h_user) begin
            rd_en = 1'b1;
          end else if (vdma_row == '0 ||
                       vdma_column == '0) begin
            rd_en    = 1'b1;
            drop_cfg = 1'b1;
          end else begin
            sof     = 1'b1;
            state_d = ST_LINE;
          end
        end
      end
      ST_LINE: begin
        if (!f_empty && load_ok) begin
          rd_en = 1'b1;
          emit  = 1'b1;
          if (line_end) begin
            if (final_line) begin
              if (paced_q)
                state_d = ST_FRAME_GAP;
              else if (enable)
                state_d = ST_WAIT_SOF;
              else
                state_d = ST_IDLE;
            end else if (paced_q && lgap_q != '0) begin
              state_d = ST_LINE_GAP;
            end
          end
        end
      end
      ST_LINE_GAP: begin
        if (load_ok && gap_done)
          state_d = ST_LINE;
      end
      ST_FRAME_GAP: begin
        if (load_ok && gap_done)
          state_d = enable ? ST_WAIT_SOF : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state     <= ST_IDLE;
      rst_done  <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      lgap_q    <= '0;
      fgap_q    <= '0;
      paced_q   <= 1'b0;
      beat_cnt  <= '0;
      line_cnt  <= '0;
      gap_cnt   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_user    <= 1'b0;
      m_last    <= 1'b0;
      out_final <= 1'b0;
      out_bad   <= 1'b0;
      frame_cnt <= '0;
      underflow <= 1'b0;
      sync_err  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state    <= state_d;
      rst_done <= 1'b1;

      if (sof) begin
        row_q    <= vdma_row;
        col_q    <= vdma_column;
        lgap_q   <= line_gap;
        fgap_q   <= frame_gap;
        paced_q  <= mode;
        beat_cnt <= '0;
        line_cnt <= '0;
      end

      if (drop_cfg)
        cfg_err <= 1'b1;

      if (state == ST_LINE && f_empty)
        underflow <= 1'b1;

      if (emit)
        gap_cnt <= '0;
      else if (in_gap && load_ok)
        gap_cnt <= gap_cnt + ONE;

      if (emit) begin
        m_valid   <= 1'b1;
        m_data    <= h_data;
        m_user    <= paced_q ? gen_user : h_user;
        m_last    <= paced_q ? gen_last : h_last;
        out_final <= line_end & final_line;
        out_bad   <= beat_bad;
        if (line_end) begin
          beat_cnt <= '0;
          line_cnt <= final_line ? '0 : line_cnt + ONE;
        end else begin
          beat_cnt <= beat_cnt + ONE;
        end
      end else if (m_axis_mm2s.tready) begin
        m_valid <= 1'b0;
      end

      // frame count and sync errors land on the handshake
      if (m_valid && m_axis_mm2s.tready) begin
        if (out_final)
          frame_cnt <= frame_cnt + ONE;
        if (out_bad)
          sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vdma_out_pacer.sv
// Directed bench for vdma_out_pacer: pacing, gaps, sync/cfg errors,
// backpressure, enable drop and async reset.
module tb_vdma_out_pacer;

  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b1;
  logic [CW-1:0] row = '0;
  logic [CW-1:0] col = '0;
  logic [CW-1:0] lgap = '0;
  logic [CW-1:0] fgap = '0;
  logic [CW-1:0] frame_cnt;
  logic          underflow;
  logic          sync_err;
  logic          cfg_err;

  vdma_out_pacer_if #(.TDATA_WIDTH(DW)) s_if();
  vdma_out_pacer_if #(.TDATA_WIDTH(DW)) m_if();

  vdma_out_pacer #(
    .TDATA_WIDTH (DW),
    .FIFO_DEPTH  (16),
    .CNT_WIDTH   (CW)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .enable         (enable),
    .mode           (mode),
    .vdma_row       (row),
    .vdma_column    (col),
    .line_gap       (lgap),
    .frame_gap      (fgap),
    .s_axis_mm2s    (s_if),
    .m_axis_mm2s    (m_if),
    .frame_cnt      (frame_cnt),
    .underflow      (underflow),
    .sync_err       (sync_err),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int stab_err = 0;

  bit src_rand = 1'b0;
  bit rdy_rand = 1'b0;

  logic [DW+1:0] src_q[$];
  logic [DW-1:0] out_d[$];
  bit            out_u[$];
  bit            out_l[$];
  int            out_c[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_out();
    out_d.delete();
    out_u.delete();
    out_l.delete();
    out_c.delete();
  endtask

  task automatic cfg(input int r, input int c,
                     input int lg, input int fg,
                     input bit md);
    row  = CW'(r);
    col  = CW'(c);
    lgap = CW'(lg);
    fgap = CW'(fg);
    mode = md;
  endtask

  // bad_last < 0: tlast at each line end; else only at that beat
  task automatic push_frame(input int r, input int c,
                            input logic [63:0] base,
                            input int bad_last);
    logic u;
    logic l;
    for (int i = 0; i < r * c; i++) begin
      u = (i == 0);
      l = (bad_last < 0) ? ((i % r) == r - 1)
                         : (i == bad_last);
      src_q.push_back({u, l, base + 64'(i)});
    end
  endtask

  task automatic wait_out(input int n, input int budget);
    int k;
    k = 0;
    while (out_d.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic scan(input  logic [63:0] base,
                      output logic [63:0] um,
                      output logic [63:0] lm,
                      output int          de);
    um = '0;
    lm = '0;
    de = 0;
    foreach (out_d[i]) begin
      if (i < 64) begin
        um[i] = out_u[i];
        lm[i] = out_l[i];
      end
      if (out_d[i] !== base + 64'(i))
        de++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    src_q.delete();
    repeat (3) @(posedge clk);
    clear_out();
    @(negedge clk);
    rst_n = 1'b1;
    settle(2);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // source driver
  initial begin
    bit hs;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    forever begin
      @(negedge clk);
      hs = s_if.tvalid && s_if.tready;
      @(posedge clk);
      #1;
      if (hs && src_q.size() > 0)
        void'(src_q.pop_front());
      if (src_q.size() > 0 &&
          (!src_rand || $urandom_range(0, 3) == 0)) begin
        {s_if.tuser, s_if.tlast, s_if.tdata} = src_q[0];
        s_if.tvalid = 1'b1;
      end else begin
        s_if.tvalid = 1'b0;
      end
    end
  end

  // sink ready
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rdy_rand ? 1'($urandom_range(0, 1))
                             : 1'b1;
    end
  end

  // output monitor and hold-stability tracker
  initial begin
    bit            hold;
    logic [DW+1:0] hval;
    hold = 1'b0;
    hval = '0;
    forever begin
      @(negedge clk);
      if (m_if.tvalid && m_if.tready) begin
        out_d.push_back(m_if.tdata);
        out_u.push_back(m_if.tuser);
        out_l.push_back(m_if.tlast);
        out_c.push_back(cyc);
      end
      if (rst_n && hold &&
          (!m_if.tvalid ||
           {m_if.tuser, m_if.tlast, m_if.tdata} !== hval))
        stab_err++;
      hold = rst_n && m_if.tvalid && !m_if.tready;
      hval = {m_if.tuser, m_if.tlast, m_if.tdata};
    end
  end

  initial begin
    logic [63:0] um;
    logic [63:0] lm;
    int          de;
    int          mn;
    int          mx;
    int          inl;
    int          idle;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {m_if.tvalid, m_if.tuser, m_if.tlast}, 0);
    chk("rst_data", m_if.tdata, 0);
    chk("rst_tready", s_if.tready, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_flags", {underflow, sync_err, cfg_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    settle(2);
    chk("tready_up", s_if.tready, 1);

    // T1: basic paced frame, no gaps
    cfg(8, 4, 0, 0, 1'b1);
    enable = 1'b1;
    push_frame(8, 4, 100, -1);
    wait_out(32, 400);
    chk("t1_n", out_d.size(), 32);
    settle(4);
    scan(100, um, lm, de);
    chk("t1_user", um, 64'h1);
    chk("t1_last", lm, 64'h8080_8080);
    chk("t1_data", de, 0);
    chk("t1_frames", frame_cnt, 1);
    chk("t1_flags", {underflow, sync_err, cfg_err}, 0);

    // T2: line gap 3, frame gap 10, two frames
    do_reset();
    cfg(8, 4, 3, 10, 1'b1);
    enable = 1'b1;
    push_frame(8, 4, 100, -1);
    push_frame(8, 4, 132, -1);
    wait_out(64, 800);
    chk("t2_n", out_d.size(), 64);
    settle(4);
    scan(100, um, lm, de);
    chk("t2_data", de, 0);
    chk("t2_last", lm, 64'h8080_8080_8080_8080);
    chk("t2_user", um, 64'h1_0000_0001);
    chk("t2_frames", frame_cnt, 2);
    if (out_d.size() == 64) begin
      mn = 1000;
      mx = 0;
      inl = 0;
      for (int i = 1; i < 64; i++) begin
        idle = out_c[i] - out_c[i-1] - 1;
        if (i % 32 == 0) begin
          chk("t2_fgap_ge10", idle >= 10, 1);
        end else if (i % 8 == 0) begin
          if (idle < mn) mn = idle;
          if (idle > mx) mx = idle;
        end else if (idle > inl) begin
          inl = idle;
        end
      end
      chk("t2_lgap_min", mn, 3);
      chk("t2_lgap_max", mx, 3);
      chk("t2_inline_idle", inl, 0);
    end

    // T3: early source tlast, paced then pass-through
    do_reset();
    cfg(8, 1, 0, 0, 1'b1);
    enable = 1'b1;
    push_frame(8, 1, 200, 5);
    wait_out(8, 300);
    chk("t3_n", out_d.size(), 8);
    settle(4);
    scan(200, um, lm, de);
    chk("t3_last", lm, 64'h80);
    chk("t3_data", de, 0);
    chk("t3_sync", sync_err, 1);
    clear_out();
    mode = 1'b0;
    push_frame(8, 1, 300, 5);
    wait_out(6, 300);
    settle(20);
    chk("t3_pt_n", out_d.size(), 6);
    scan(300, um, lm, de);
    chk("t3_pt_last", lm, 64'h20);
    chk("t3_pt_user", um, 64'h1);
    chk("t3_pt_data", de, 0);
    chk("t3_frames", frame_cnt, 2);

    // T4: random sink ready, sparse source
    do_reset();
    cfg(4, 4, 1, 2, 1'b1);
    enable = 1'b1;
    src_rand = 1'b1;
    rdy_rand = 1'b1;
    stab_err = 0;
    push_frame(4, 4, 400, -1);
    wait_out(16, 2000);
    chk("t4_n", out_d.size(), 16);
    settle(6);
    src_rand = 1'b0;
    rdy_rand = 1'b0;
    scan(400, um, lm, de);
    chk("t4_data", de, 0);
    chk("t4_user", um, 64'h1);
    chk("t4_last", lm, 64'h8888);
    chk("t4_uf", underflow, 1);
    chk("t4_stable", stab_err, 0);
    chk("t4_frames", frame_cnt, 1);

    // T5: junk before SOF, then zero row
    do_reset();
    cfg(4, 1, 0, 0, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 3; i++)
      src_q.push_back({2'b00, 64'hDEAD_0000 + 64'(i)});
    push_frame(4, 1, 500, -1);
    wait_out(4, 300);
    settle(4);
    scan(500, um, lm, de);
    chk("t5_data", de, 0);
    chk("t5_last", lm, 64'h8);
    chk("t5_cfg_ok", cfg_err, 0);
    row = '0;
    push_frame(4, 1, 600, -1);
    settle(30);
    chk("t5_zero_n", out_d.size(), 4);
    chk("t5_cfg_err", cfg_err, 1);
    chk("t5_frames", frame_cnt, 1);

    // T6: enable drop mid-frame, then async reset mid-line
    do_reset();
    cfg(4, 2, 0, 0, 1'b1);
    enable = 1'b1;
    push_frame(4, 2, 700, -1);
    push_frame(4, 2, 708, -1);
    wait_out(3, 300);
    enable = 1'b0;
    settle(40);
    chk("t6_n", out_d.size(), 8);
    chk("t6_frames", frame_cnt, 1);
    chk("t6_src_done", src_q.size(), 0);
    chk("t6_idle_valid", m_if.tvalid, 0);
    enable = 1'b1;
    wait_out(10, 300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl",
        {m_if.tvalid, m_if.tuser, m_if.tlast}, 0);
    chk("t6_rst_data", m_if.tdata, 0);
    chk("t6_rst_cnt", frame_cnt, 0);
    chk("t6_rst_tready", s_if.tready, 0);
    src_q.delete();
    repeat (2) @(posedge clk);
    clear_out();
    @(negedge clk);
    rst_n = 1'b1;
    cfg(4, 1, 0, 0, 1'b1);
    push_frame(4, 1, 800, -1);
    wait_out(4, 300);
    settle(10);
    chk("t6_re_n", out_d.size(), 4);
    scan(800, um, lm, de);
    chk("t6_re_data", de, 0);
    chk("t6_re_user", um, 64'h1);
    chk("t6_re_last", lm, 64'h8);
    chk("t6_re_frames", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
